wb_sram_ctrl: RTL and testbench

Parametrised Wishbone B4 slave fronting an inferred, byte-lane-writable single-port SRAM; successor to the fixed 32-bit / 16K-word SRAM slave. Adds generic width and depth, configurable SRAM read latency, registered-feedback incrementing bursts (one beat per cycle at RD_LAT=1) and error termination for out-of-range addresses. Sits on the SoC data/instruction bus as the main on-chip RAM.

---
 rtl/wb_sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_ctrl.sv
// Wishbone B4 slave in front of an inferred byte-writable single-port SRAM.
// Supports classic cycles, registered-feedback incrementing bursts and error
// termination for addresses at or beyond DEPTH.
module wb_sram_ctrl #(
  parameter int unsigned ASIZE  = 14,
  parameter int unsigned DSIZE  = 32,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cyc,
  input  logic               i_stb,
  input  logic               i_we,
  input  logic [ASIZE-1:0]   i_adr,
  input  logic [DSIZE/8-1:0] i_sel,
  input  logic [DSIZE-1:0]   i_dat,
  input  logic [2:0]         i_cti,
  output logic               o_ack,
  output logic               o_err,
  output logic [DSIZE-1:0]   o_dat
);

  localparam int unsigned NB = DSIZE / 8;
  // One extra address bit so a burst increment past the top cannot wrap to 0.
  localparam logic [ASIZE:0] DepthA = (ASIZE + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StAck, StBurst, StErr} state_e;

  state_e           state_q, state_d;
  logic [ASIZE:0]   addr_q, addr_d, addr_inc, ra;
  logic             cls_q, cls_d;
  logic             req, re, mem_re, mem_we;
  logic [ASIZE-1:0] wa, ra_idx;
  logic [DSIZE-1:0] ram_q, pipe_q, hold_q, rd_data;
  logic [DSIZE-1:0] mem [DEPTH];

  assign req      = i_cyc & i_stb;
  assign addr_inc = addr_q + (ASIZE + 1)'(1);
  assign mem_we   = o_ack & i_we;
  assign mem_re   = re && (ra < DepthA);
  assign wa       = addr_q[ASIZE-1:0];
  assign ra_idx   = ra[ASIZE-1:0];
  assign rd_data  = (RD_LAT == 2) ? pipe_q : ram_q;
  // Outside an ack cycle the last acked word is held.
  assign o_dat    = o_ack ? rd_data : hold_q;

  // Next-state, SRAM read request and gated bus responses.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cls_d   = cls_q;
    re      = 1'b0;
    ra      = addr_q;
    o_ack   = 1'b0;
    o_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d = {1'b0, i_adr};
          cls_d  = !((i_cti == 3'b010) || (i_cti == 3'b111));
          if ({1'b0, i_adr} >= DepthA) begin
            state_d = StErr;
          end else begin
            re      = !i_we;
            ra      = {1'b0, i_adr};
            state_d = ((RD_LAT == 2) && !i_we) ? StWait : StAck;
          end
        end
      end
      StWait: state_d = StAck;
      StAck: begin
        o_ack = req;
        if (req) begin
          if (!cls_q && (RD_LAT == 1) && (i_cti == 3'b010)) begin
            state_d = StBurst;
            addr_d  = addr_inc;
            re      = 1'b1;
            ra      = addr_inc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBurst: begin
        if (req) begin
          if (addr_q >= DepthA) begin
            o_err   = 1'b1;
            state_d = StIdle;
          end else begin
            o_ack  = 1'b1;
            addr_d = addr_inc;
            re     = 1'b1;
            ra     = addr_inc;
            if (i_cti != 3'b010) state_d = StIdle;
          end
        end else begin
          // Master wait state: keep the current word on the read port.
          re = 1'b1;
          ra = addr_q;
        end
      end
      StErr: begin
        o_err = req;
        if (req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!i_cyc) state_d = StIdle;
  end

  // Control state, read pipeline stage and held read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cls_q   <= 1'b1;
      pipe_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cls_q   <= cls_d;
      pipe_q  <= ram_q;
      if (o_ack) hold_q <= rd_data;
    end
  end

  // SRAM array: byte-lane writes, registered read with write-first bypass.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we && i_sel[b]) mem[wa][8*b +: 8] <= i_dat[8*b +: 8];
      if (mem_re) begin
        ram_q[8*b +: 8] <= (mem_we && i_sel[b] && (ra_idx == wa)) ? i_dat[8*b +: 8]
                                                                   : mem[ra_idx][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench: two instances (RD_LAT=1 and RD_LAT=2, DEPTH=1000)
// driven through one master, compared against a word-array memory model.
module tb_wb_sram_ctrl;

  localparam int unsigned Depth = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we_s;
  logic [9:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic [2:0]  cti;
  int          dsel;
  logic        ack1, err1, ack2, err2, ack_m, err_m;
  logic [31:0] dat1, dat2, dat_m;
  logic        cyc1, cyc2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl [2][1024];
  logic [31:0] last_dat [2];
  bit          known [2];
  logic [31:0] wdat_a [8];
  logic [3:0]  wsel_a [8];
  logic [31:0] rdat_a [8];

  always #5 clk = ~clk;

  assign cyc1  = cyc & (dsel == 0);
  assign cyc2  = cyc & (dsel == 1);
  assign ack_m = (dsel == 1) ? ack2 : ack1;
  assign err_m = (dsel == 1) ? err2 : err1;
  assign dat_m = (dsel == 1) ? dat2 : dat1;

  wb_sram_ctrl #(.ASIZE(10), .DSIZE(32), .DEPTH(Depth), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc1), .i_stb(stb), .i_we(we_s), .i_adr(adr),
    .i_sel(sel), .i_dat(dat), .i_cti(cti), .o_ack(ack1), .o_err(err1), .o_dat(dat1)
  );

  wb_sram_ctrl #(.ASIZE(10), .DSIZE(32), .DEPTH(Depth), .RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc2), .i_stb(stb), .i_we(we_s), .i_adr(adr),
    .i_sel(sel), .i_dat(dat), .i_cti(cti), .o_ack(ack2), .o_err(err2), .o_dat(dat2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] cti_of(input int i, input int n);
    if (n == 1) return 3'b000;
    return (i == n - 1) ? 3'b111 : 3'b010;
  endfunction

  // One transfer of n beats (n==1 is a classic cycle). Optionally drops i_stb
  // for wait_len cycles before beat wait_at.
  task automatic xfer(input int d, input bit we, input int base, input int n,
                      input int wait_at, input int wait_len);
    int cnt;
    int addr;
    int lat;
    @(posedge clk); #1;
    dsel = d; cyc = 1'b1; stb = 1'b1; we_s = we; adr = base[9:0];
    sel = wsel_a[0]; dat = wdat_a[0]; cti = cti_of(0, n);
    cnt = 0;
    do begin
      @(posedge clk); cnt++;
      @(negedge clk);
    end while (!(ack_m || err_m) && cnt < 6);
    lat = (base >= Depth) ? 1 : ((!we && d == 1) ? 2 : 1);
    check_eq("first_latency", cnt, lat);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == wait_at) begin
          stb = 1'b0;
          repeat (wait_len) begin
            @(negedge clk);
            check_eq("wait_no_resp", {ack_m, err_m}, 2'b00);
            @(posedge clk); #1;
          end
          stb = 1'b1;
        end
        adr = 10'($urandom); sel = wsel_a[i]; dat = wdat_a[i]; cti = cti_of(i, n);
        @(negedge clk);
      end
      addr = base + i;
      if (addr >= Depth) begin
        check_eq("resp_err", {ack_m, err_m}, 2'b01);
        if (known[d]) check_eq("err_dat_held", dat_m, last_dat[d]);
        break;
      end
      check_eq("resp_ack", {ack_m, err_m}, 2'b10);
      if (!we) begin
        check_eq("rdata", dat_m, mdl[d][addr]);
        rdat_a[i]   = dat_m;
        last_dat[d] = mdl[d][addr];
        known[d]    = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wsel_a[i][b]) mdl[d][addr][8*b +: 8] = wdat_a[i][8*b +: 8];
        end
        known[d] = 1'b0;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic write1(input int d, input int a, input logic [31:0] v, input logic [3:0] s);
    wdat_a[0] = v; wsel_a[0] = s;
    xfer(d, 1'b1, a, 1, -1, 0);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we_s = 1'b0; adr = '0; sel = '0; dat = '0;
    cti = '0; dsel = 0;
    known[0] = 1'b1; known[1] = 1'b1; last_dat[0] = '0; last_dat[1] = '0;
    #12;
    check_eq("rst_ack1", ack1, 1'b0);
    check_eq("rst_err1", err1, 1'b0);
    check_eq("rst_dat1", dat1, 32'h0);
    check_eq("rst_ack2", ack2, 1'b0);
    check_eq("rst_err2", err2, 1'b0);
    check_eq("rst_dat2", dat2, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Give every implemented word a known value in both instances.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < Depth; a++) write1(d, a, $urandom, 4'hF);
    end

    // Classic write/read and byte lanes.
    write1(0, 5, 32'hDEADBEEF, 4'hF);
    xfer(0, 1'b0, 5, 1, -1, 0);
    check_eq("classic_rd", rdat_a[0], 32'hDEADBEEF);
    write1(0, 5, 32'h11223344, 4'b0101);
    xfer(0, 1'b0, 5, 1, -1, 0);
    check_eq("lane_rd", rdat_a[0], 32'hDE22BE44);

    // 4-beat read burst from 8, then a classic read proves return to idle.
    for (int i = 0; i < 4; i++) write1(0, 8 + i, 32'hA0 + i, 4'hF);
    xfer(0, 1'b0, 8, 4, -1, 0);
    for (int i = 0; i < 4; i++) check_eq("burst_rd", rdat_a[i], 32'hA0 + i);
    xfer(0, 1'b0, 9, 1, -1, 0);

    // Write burst with a 2-cycle master wait before the third beat.
    for (int i = 0; i < 4; i++) begin
      wdat_a[i] = 32'hC0DE0000 + i; wsel_a[i] = 4'hF;
    end
    xfer(0, 1'b1, 20, 4, 2, 2);
    for (int i = 0; i < 5; i++) xfer(0, 1'b0, 19 + i, 1, -1, 0);

    // Range errors.
    write1(0, 1000, 32'h12345678, 4'hF);
    xfer(0, 1'b0, 998, 4, -1, 0);
    xfer(0, 1'b0, 1022, 3, -1, 0);
    write1(1, 1010, 32'h55555555, 4'hF);

    // Drop i_cyc during the ack cycle of a write: nothing may commit.
    @(posedge clk); #1;
    dsel = 0; cyc = 1'b1; stb = 1'b1; we_s = 1'b1; adr = 10'd7; sel = 4'hF;
    dat = ~mdl[0][7]; cti = 3'b000;
    @(posedge clk); @(negedge clk);
    check_eq("abort_ack_seen", ack_m, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    #1;
    check_eq("abort_ack_drop", ack_m, 1'b0);
    known[0] = 1'b0;
    xfer(0, 1'b0, 7, 1, -1, 0);

    // Reset while an RD_LAT=2 read sits in its wait cycle.
    @(posedge clk); #1;
    dsel = 1; cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr = 10'd3; cti = 3'b000;
    @(posedge clk); @(negedge clk);
    check_eq("wait_no_ack", ack_m, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ack", ack_m, 1'b0);
    check_eq("rst_mid_dat", dat2, 32'h0);
    @(posedge clk); @(negedge clk);
    check_eq("rst_hold_ack", ack_m, 1'b0);
    cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
    known[0] = 1'b1; known[1] = 1'b1; last_dat[0] = '0; last_dat[1] = '0;
    xfer(1, 1'b0, 3, 1, -1, 0);

    // Randomised traffic on both instances.
    for (int k = 0; k < 150; k++) begin
      int base;
      int n;
      n    = $urandom_range(1, 4);
      base = ($urandom_range(0, 9) == 0) ? $urandom_range(995, 1023) : $urandom_range(0, 999);
      for (int i = 0; i < 8; i++) begin
        wdat_a[i] = $urandom; wsel_a[i] = 4'($urandom);
      end
      xfer(0, 1'($urandom), base, n, $urandom_range(1, 4), $urandom_range(1, 2));
    end
    for (int k = 0; k < 80; k++) begin
      int base;
      base = ($urandom_range(0, 9) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 999);
      wdat_a[0] = $urandom; wsel_a[0] = 4'($urandom);
      xfer(1, 1'($urandom), base, 1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
